// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit prescaled mtime, 64-bit compare, sticky
// pending bit with one-shot or auto-reload behaviour, single-cycle register port.
module machine_timer #(
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        interrupt_t
);

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_MTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd4;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd5;

  logic        en_reg, en_next;
  logic        periodic_reg, periodic_next;
  logic [7:0]  prescale_reg, prescale_next;
  logic [7:0]  pcnt_reg, pcnt_next;
  logic        pend_reg, pend_next;
  logic [63:0] mtime_reg, mtime_next;
  logic [63:0] cmp_reg, cmp_next;
  logic [31:0] shadow_reg, shadow_next;
  logic        ack_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic        irq_reg;

  logic [7:0]  wr_sel;
  logic        rd_en;
  logic        mtime_wr;
  logic        tick;
  logic        match;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_wr_sel
      assign wr_sel[gi] = req && we && (addr == gi[2:0]);
    end
  endgenerate

  assign rd_en    = req && !we;
  assign mtime_wr = wr_sel[ADDR_MTIME_LO] || wr_sel[ADDR_MTIME_HI];

  // A CTRL write that clears EN suppresses the tick on that same edge.
  assign tick  = en_reg && (pcnt_reg == prescale_reg) &&
                 !(wr_sel[ADDR_CTRL] && !wdata[0]);
  assign match = tick && !mtime_wr && (mtime_reg == cmp_reg);

  always_comb begin
    en_next       = en_reg;
    periodic_next = periodic_reg;
    prescale_next = prescale_reg;
    if (wr_sel[ADDR_CTRL]) begin
      en_next       = wdata[0];
      periodic_next = wdata[1];
      prescale_next = wdata[15:8];
    end

    pcnt_next = pcnt_reg + 8'd1;
    if (wr_sel[ADDR_CTRL] || !en_reg || tick) begin
      pcnt_next = 8'd0;
    end

    // Register writes to mtime take priority over the tick increment.
    mtime_next = mtime_reg;
    if (wr_sel[ADDR_MTIME_LO]) begin
      mtime_next[31:0] = wdata;
    end else if (wr_sel[ADDR_MTIME_HI]) begin
      mtime_next[63:32] = wdata;
    end else if (tick) begin
      mtime_next = (match && periodic_reg) ? 64'd0 : mtime_reg + 64'd1;
    end

    cmp_next = cmp_reg;
    if (wr_sel[ADDR_CMP_LO]) begin
      cmp_next[31:0] = wdata;
    end else if (wr_sel[ADDR_CMP_HI]) begin
      cmp_next[63:32] = wdata;
    end

    pend_next = (pend_reg && !(wr_sel[ADDR_STATUS] && wdata[0])) || match;

    shadow_next = shadow_reg;
    if (rd_en && addr == ADDR_MTIME_LO) begin
      shadow_next = mtime_reg[63:32];
    end

    rdata_next = 32'd0;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:     rdata_next = {16'd0, prescale_reg, 6'd0, periodic_reg, en_reg};
        ADDR_STATUS:   rdata_next = {31'd0, pend_reg};
        ADDR_MTIME_LO: rdata_next = mtime_reg[31:0];
        ADDR_MTIME_HI: rdata_next = shadow_reg;
        ADDR_CMP_LO:   rdata_next = cmp_reg[31:0];
        ADDR_CMP_HI:   rdata_next = cmp_reg[63:32];
        default:       rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg       <= 1'b0;
      periodic_reg <= 1'b0;
      prescale_reg <= 8'd0;
      pcnt_reg     <= 8'd0;
      pend_reg     <= 1'b0;
      mtime_reg    <= 64'd0;
      cmp_reg      <= CMP_RESET;
      shadow_reg   <= 32'd0;
      ack_reg      <= 1'b0;
      rdata_reg    <= 32'd0;
      irq_reg      <= 1'b0;
    end else begin
      en_reg       <= en_next;
      periodic_reg <= periodic_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      pend_reg     <= pend_next;
      mtime_reg    <= mtime_next;
      cmp_reg      <= cmp_next;
      shadow_reg   <= shadow_next;
      ack_reg      <= req;
      rdata_reg    <= rdata_next;
      irq_reg      <= pend_reg;
    end
  end

  assign ack         = ack_reg;
  assign rdata       = rdata_reg;
  assign interrupt_t = irq_reg;

endmodule

// File: tb/tb_machine_timer.sv
// Scoreboard bench for machine_timer: each access queues its expected ack/rdata,
// a negedge monitor pops and checks; interrupt_t is checked at fixed cycles.
module tb_machine_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic        ack;
  logic [31:0] rdata;
  logic        interrupt_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  machine_timer #(.CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata),
    .interrupt_t(interrupt_t)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: an entry is due exactly one cycle after its request was issued.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check({e.tag, " ack"}, {31'd0, ack}, 32'd1);
      check(e.tag, rdata, e.data);
      $display("txn %-14s rdata=%h expected=%h", e.tag, rdata, e.data);
    end else begin
      check("idle ack", {31'd0, ack}, 32'd0);
      check("idle rdata", rdata, 32'd0);
    end
  end

  task automatic acc(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string tag);
    exp_t x;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    x.data = e;
    x.due  = cyc + 1;
    x.tag  = tag;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    acc(1'b1, a, d, 32'd0, $sformatf("wr[%0d]", a));
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    acc(1'b0, a, 32'd0, e, $sformatf("rd[%0d]", a));
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    we  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_irq(input string name, input logic v);
    check(name, {31'd0, interrupt_t}, {31'd0, v});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset ack", {31'd0, ack}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    chk_irq("reset irq", 1'b0);
    rst = 1'b0;

    // Reset values of every register, reserved words read 0 and ignore writes.
    rd(0, 32'd0);
    rd(1, 32'd0);
    rd(2, 32'd0);
    rd(3, 32'd0);
    rd(4, 32'hFFFF_FFFF);
    rd(5, 32'hFFFF_FFFF);
    rd(6, 32'd0);
    rd(7, 32'd0);
    wr(6, 32'hDEAD_BEEF);
    rd(6, 32'd0);
    idle(1);

    // One-shot, cmp=5, prescale 0: match on 6th tick (edge B+6).
    wr(4, 32'd5);
    wr(5, 32'd0);
    wr(0, 32'h1);            // B
    idle(6);                 // B+6
    chk_irq("oneshot irq before", 1'b0);
    idle(1);                 // B+7
    chk_irq("oneshot irq rise", 1'b1);
    rd(2, 32'd7);            // B+8
    rd(1, 32'd1);            // B+9
    wr(1, 32'd1);            // B+10 W1C
    chk_irq("oneshot irq hold", 1'b1);
    idle(1);                 // B+11
    chk_irq("oneshot irq drop", 1'b0);
    rd(1, 32'd0);

    // Not re-raised until mtime wraps back to 5.
    wr(0, 32'h0);
    wr(2, 32'hFFFF_FFFD);
    wr(3, 32'hFFFF_FFFF);
    wr(0, 32'h1);            // D
    idle(9);                 // D+9
    chk_irq("wrap irq before", 1'b0);
    idle(1);                 // D+10
    chk_irq("wrap irq rise", 1'b1);
    wr(0, 32'h0);            // D+11, counting stops here
    wr(1, 32'd1);
    rd(2, 32'd7);
    rd(3, 32'd0);

    // Periodic, prescale 3, cmp 2: PEND every 12 cycles.
    wr(2, 32'd0);
    wr(4, 32'd2);
    wr(0, 32'h303);          // P
    rd(0, 32'h303);          // P+1
    idle(11);                // P+12
    chk_irq("periodic irq before", 1'b0);
    idle(1);                 // P+13
    chk_irq("periodic irq rise1", 1'b1);
    wr(1, 32'd1);            // P+14
    idle(1);                 // P+15
    chk_irq("periodic irq drop", 1'b0);
    idle(9);                 // P+24
    chk_irq("periodic irq gap", 1'b0);
    idle(1);                 // P+25
    chk_irq("periodic irq rise2", 1'b1);
    rd(2, 32'd0);            // P+26
    wr(1, 32'd1);            // P+27
    idle(8);                 // P+35
    wr(1, 32'd1);            // P+36 W1C collides with match: set wins
    rd(1, 32'd1);            // P+37
    rd(2, 32'd0);            // P+38
    idle(1);                 // P+39
    wr(2, 32'h10);           // P+40 tick cycle: write wins
    rd(2, 32'h10);           // P+41

    // Coherent 64-bit read across a low-word carry.
    wr(0, 32'h0);
    wr(1, 32'd1);
    wr(2, 32'hFFFF_FFFE);
    wr(3, 32'd0);
    wr(0, 32'h1);            // F
    rd(2, 32'hFFFF_FFFE);    // F+1
    idle(1);                 // F+2 carry
    rd(3, 32'd0);            // F+3 shadow
    rd(2, 32'd1);            // F+4
    rd(3, 32'd1);            // F+5

    // CMP write in a match-tick cycle uses the old compare value.
    wr(0, 32'h0);
    wr(1, 32'd1);
    wr(2, 32'd0);
    wr(3, 32'd0);
    wr(0, 32'h1);            // E
    idle(2);                 // E+2
    wr(4, 32'h100);          // E+3 match on old cmp=2
    rd(1, 32'd1);
    rd(4, 32'h100);
    idle(1);
    chk_irq("pre-reset irq", 1'b1);

    // Asynchronous reset with a read in flight.
    rst   = 1'b1;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 3'd2;
    #1;
    chk_irq("async reset irq", 1'b0);
    check("async reset ack", {31'd0, ack}, 32'd0);
    check("async reset rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    rd(0, 32'd0);
    rd(1, 32'd0);
    rd(2, 32'd0);
    rd(3, 32'd0);
    rd(4, 32'hFFFF_FFFF);
    rd(5, 32'hFFFF_FFFF);
    wr(0, 32'h1);            // G
    idle(1);                 // G+1 first tick
    rd(2, 32'd1);
    idle(2);

    check("queue drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped machine timer that produces the level timer interrupt `interrupt_t` consumed by the CPU interrupt controller. It holds a 64-bit `mtime` counter, driven by an 8-bit prescaler, and a 64-bit compare register. On a compare match it sets a sticky pending bit, in either one-shot or periodic (auto-reload) mode. Software configures and clears it through a single-cycle register port on the CPU data bus.

## Interface
- `CMP_RESET`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of the compare register.
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `req`  input  1  register access request, one access per cycle, back-to-back allowed.
- `we`  input  1  1 = write, 0 = read; qualified by `req`.
- `addr`  input  3  word index (byte address bits [4:2]).
- `wdata`  input  32  write data; full-word writes only.
- `ack`  output  1  access complete, exactly one cycle after `req`.
- `rdata`  output  32  read data, valid while `ack`=1; 0 otherwise.
- `interrupt_t`  output  1  registered copy of `STATUS.PEND`, to the interrupt controller.

## Operation
- Register map (word index):
  - 0 `CTRL`: bit0 `EN`, bit1 `PERIODIC`, bits[15:8] `PRESCALE`; other bits read 0.
  - 1 `STATUS`: bit0 `PEND`. Writing 1 clears it; writing 0 has no effect.
  - 2 `MTIME_LO`.
  - 3 `MTIME_HI`.
  - 4 `CMP_LO`.
  - 5 `CMP_HI`.
  - 6–7: read 0, writes ignored, still acked.
- Prescaler (8-bit `pcnt`):
  - Held at 0 while `EN`=0. Reset to 0 on any `CTRL` write.
  - While `EN`=1: if `pcnt`==`PRESCALE`, assert `tick` and set `pcnt` to 0; otherwise increment `pcnt`.
  - One tick every `PRESCALE`+1 cycles.
- Counter update on a tick:
  - If `mtime`==`cmp`: set `PEND`. If `PERIODIC`=1, `mtime` goes to 0; otherwise `mtime`+1.
  - If no match: `mtime`+1, wrapping all-ones to 0 with no flag.
  - Match is evaluated only on ticks. A match that arises purely from register writes does not set `PEND`.
- 64-bit read coherency: reading `MTIME_LO` latches the current `mtime[63:32]` into a shadow register. Reading `MTIME_HI` returns the shadow, not the live value.
- 64-bit writes: each half is written independently, with no shadowing.
- Simultaneous events:
  - `MTIME_*` write in a tick cycle: the write wins, with no increment and no match evaluation that cycle. The untouched half keeps its value.
  - `CMP_*` write in a tick cycle: match uses the old `cmp`; the new value applies from the next cycle.
  - `PEND` set and W1C in the same cycle: set wins.
  - `CTRL` write clearing `EN`: counting stops the same edge; `mtime` and `PEND` hold.
- Reset values: `CTRL`=0, `PEND`=0, `mtime`=0, `cmp`=`CMP_RESET`, shadow=0, `pcnt`=0, `ack`=0, `rdata`=0, `interrupt_t`=0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). An in-flight access is dropped with no `ack`.

## Timing
- Read or write accepted at edge N (`req`=1) produces `ack`=1 and `rdata` during cycle N+1.
- Read data reflects register state before edge N, so a read in the same cycle as a write to that register returns the old value.
- Write side effects are visible from cycle N+1.
- Tick at edge N with match sets `PEND` at edge N; `interrupt_t` rises at edge N+1 (one register stage).
- W1C of `PEND` at edge N drops `interrupt_t` at edge N+1. The controller's timeout state exits on that deassertion.
- Periodic mode: consecutive `PEND` sets are (`cmp`+1)·(`PRESCALE`+1) cycles apart.

## Test plan
- Reset, then read every register. Expect `CTRL`=0, `STATUS`=0, `MTIME`=0, `CMP_LO`=`CMP_HI`=0xFFFFFFFF, `interrupt_t`=0, `ack` one cycle after each `req`.
- One-shot: `CMP`=5, `PRESCALE`=0, `EN`=1 with `mtime`=0. Expect `PEND` set at the 6th tick and `interrupt_t` one cycle later. `mtime` continues to 6, 7, …. W1C drops `interrupt_t` next cycle, and it is not re-raised until `mtime` wraps back to 5.
- Periodic with `PRESCALE`=3, `CMP`=2: the `mtime` sequence is 0,1,2,0,… with 4 cycles per step. Clearing `PEND` each time, `PEND` sets every 12 cycles.
- Coherency: `mtime`=0x0000_0000_FFFF_FFFE, `PRESCALE`=0. Read `LO` (expect 0xFFFFFFFE), then read `HI` after the carry. `HI` must return 0 (shadow), while a fresh `LO`/`HI` pair returns the post-wrap value 0x1_xxxx.
- Collisions: W1C in the same cycle as a match leaves `PEND`=1. An `MTIME_LO`=0x10 write in a tick cycle gives `mtime`=0x10 with no increment. A `CMP` write in a match-tick cycle sets `PEND` using the old `cmp`.
- Assert `rst` for 1 cycle mid-count while `PEND`=1 and a read is in flight. All outputs go to reset values immediately, no `ack` is produced, and counting resumes only after `EN` is rewritten.
